// File: rtl/mem_bus_arbiter.sv
// Two-core main-memory bus arbiter: round-robin grant, one-cycle snoop
// broadcast to the non-owning core, fixed-latency memory access.
module mem_bus_arbiter #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_1,
   input  logic              req_2,
   input  logic              wr_1,
   input  logic              wr_2,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [ADDR_W-1:0] addr_2,
   input  logic [DATA_W-1:0] wdata_1,
   input  logic [DATA_W-1:0] wdata_2,
   output logic              gnt_1,
   output logic              gnt_2,
   output logic              done_1,
   output logic              done_2,
   output logic [DATA_W-1:0] rdata,
   output logic              shared,
   output logic              snoop_valid_1,
   output logic              snoop_valid_2,
   output logic [ADDR_W-1:0] snoop_addr,
   output logic              snoop_wr,
   input  logic              snoop_hit_1,
   input  logic              snoop_hit_2,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CW = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {IDLE, SNOOP, ACCESS, DONE} state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic              owner_q;
   logic              last_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              gnt1_q, gnt2_q;
   logic              done1_q, done2_q;
   logic              sv1_q, sv2_q;
   logic              en_q, we_q;
   logic              shared_q;
   logic [DATA_W-1:0] rdata_q;
   logic              sel2_d;

   // owner/last encoding: 0 = core 1, 1 = core 2
   assign sel2_d = req_2 & (~req_1 | ~last_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         gnt1_q   <= 1'b0;
         gnt2_q   <= 1'b0;
         done1_q  <= 1'b0;
         done2_q  <= 1'b0;
         sv1_q    <= 1'b0;
         sv2_q    <= 1'b0;
         en_q     <= 1'b0;
         we_q     <= 1'b0;
         shared_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_1 | req_2) begin
                  state_q <= SNOOP;
                  owner_q <= sel2_d;
                  last_q  <= sel2_d;
                  wr_q    <= sel2_d ? wr_2 : wr_1;
                  addr_q  <= sel2_d ? addr_2 : addr_1;
                  wdata_q <= sel2_d ? wdata_2 : wdata_1;
                  gnt1_q  <= ~sel2_d;
                  gnt2_q  <= sel2_d;
                  sv1_q   <= sel2_d;
                  sv2_q   <= ~sel2_d;
               end
            end
            SNOOP: begin
               state_q  <= ACCESS;
               sv1_q    <= 1'b0;
               sv2_q    <= 1'b0;
               shared_q <= owner_q ? snoop_hit_1 : snoop_hit_2;
               en_q     <= 1'b1;
               we_q     <= wr_q;
               cnt_q    <= CW'(MEM_LAT - 1);
            end
            ACCESS: begin
               if (cnt_q == '0) begin
                  state_q <= DONE;
                  en_q    <= 1'b0;
                  we_q    <= 1'b0;
                  done1_q <= ~owner_q;
                  done2_q <= owner_q;
                  if (!wr_q) rdata_q <= mem_rdata;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               gnt1_q  <= 1'b0;
               gnt2_q  <= 1'b0;
               done1_q <= 1'b0;
               done2_q <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_1         = gnt1_q;
   assign gnt_2         = gnt2_q;
   assign done_1        = done1_q;
   assign done_2        = done2_q;
   assign rdata         = rdata_q;
   assign shared        = shared_q;
   assign snoop_valid_1 = sv1_q;
   assign snoop_valid_2 = sv2_q;
   assign snoop_addr    = addr_q;
   assign snoop_wr      = wr_q;
   assign mem_en        = en_q;
   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed vector table, hand-written
// corner sequences, then random traffic against a transaction-level model.
module tb_mem_bus_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int ML = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_1, req_2, wr_1, wr_2;
   logic [AW-1:0] addr_1, addr_2;
   logic [DW-1:0] wdata_1, wdata_2;
   logic          gnt_1, gnt_2, done_1, done_2;
   logic [DW-1:0] rdata;
   logic          shared, snoop_valid_1, snoop_valid_2;
   logic [AW-1:0] snoop_addr;
   logic          snoop_wr, snoop_hit_1, snoop_hit_2;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic          tbl_mode;
   logic [DW-1:0] tbl_mrd;
   logic [DW-1:0] memarr [32];

   always #5 clk = ~clk;

   always_comb mem_rdata = tbl_mode ? tbl_mrd : memarr[mem_addr];

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(ML)) dut (
      .clk(clk), .reset(reset),
      .req_1(req_1), .req_2(req_2), .wr_1(wr_1), .wr_2(wr_2),
      .addr_1(addr_1), .addr_2(addr_2),
      .wdata_1(wdata_1), .wdata_2(wdata_2),
      .gnt_1(gnt_1), .gnt_2(gnt_2), .done_1(done_1), .done_2(done_2),
      .rdata(rdata), .shared(shared),
      .snoop_valid_1(snoop_valid_1), .snoop_valid_2(snoop_valid_2),
      .snoop_addr(snoop_addr), .snoop_wr(snoop_wr),
      .snoop_hit_1(snoop_hit_1), .snoop_hit_2(snoop_hit_2),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   int errs = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // {g1,g2,d1,d2,sv1,sv2,en,we}
   function automatic logic [7:0] ctl_now();
      return {gnt_1, gnt_2, done_1, done_2,
              snoop_valid_1, snoop_valid_2, mem_en, mem_we};
   endfunction

   typedef struct {
      logic          r1, r2, w1, w2;
      logic [AW-1:0] a1, a2;
      logic [DW-1:0] d1, d2;
      logic          h1, h2;
      logic [DW-1:0] mrd;
      logic [7:0]    ctl;
      logic          sw;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd;
      logic [DW-1:0] erd;
      logic          esh;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r1, r2, w1, w2,
                      input logic [AW-1:0] a1, a2,
                      input logic [DW-1:0] d1, d2,
                      input logic h1, h2,
                      input logic [DW-1:0] mrd,
                      input logic [7:0] ctl,
                      input logic sw,
                      input logic [AW-1:0] ea,
                      input logic [DW-1:0] ewd, erd,
                      input logic esh);
      vec_t v;
      v.r1 = r1; v.r2 = r2; v.w1 = w1; v.w2 = w2;
      v.a1 = a1; v.a2 = a2; v.d1 = d1; v.d2 = d2;
      v.h1 = h1; v.h2 = h2; v.mrd = mrd; v.ctl = ctl;
      v.sw = sw; v.ea = ea; v.ewd = ewd; v.erd = erd;
      v.esh = esh;
      tbl.push_back(v);
   endtask

   // transaction-level reference model: a grant at edge k puts the
   // owner in snoop at offset 0, memory at 1..ML, done at ML+1
   int            tcnt;
   int            k_m;
   int            last_m;
   bit            busy_m;
   bit            own2_m;
   logic          mw_m;
   logic [AW-1:0] ma_m;
   logic [DW-1:0] mwd_m;
   logic [DW-1:0] rd_m;
   logic          sh_m;

   task automatic model_step();
      int d;
      if (busy_m) begin
         d = tcnt - k_m;
         if (d == 1) sh_m = own2_m ? snoop_hit_1 : snoop_hit_2;
         if (d == ML + 1 && !mw_m) rd_m = memarr[ma_m];
         if (d == ML + 2) busy_m = 0;
      end else if (req_1 || req_2) begin
         own2_m = req_2 && (!req_1 || last_m == 1);
         last_m = own2_m ? 2 : 1;
         mw_m   = own2_m ? wr_2 : wr_1;
         ma_m   = own2_m ? addr_2 : addr_1;
         mwd_m  = own2_m ? wdata_2 : wdata_1;
         busy_m = 1;
         k_m    = tcnt;
      end
   endtask

   function automatic logic [7:0] exp_ctl();
      int   d;
      logic g, s, e, dn;
      d  = tcnt - k_m;
      g  = busy_m;
      s  = busy_m && d == 0;
      e  = busy_m && d >= 1 && d <= ML;
      dn = busy_m && d == ML + 1;
      return {g && !own2_m, g && own2_m, dn && !own2_m, dn && own2_m,
              s && own2_m, s && !own2_m, e, e && mw_m};
   endfunction

   task automatic wait_en(input string nm);
      int n = 0;
      while (!mem_en && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_reached"}, mem_en, 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int own_q[$];
      int gap_q[$];
      int gap, c, cd, cg, n;
      bit ovl, prev, seen, bad;
      int idle1, idle2;
      logic [7:0] ec;

      tbl_mode = 1'b1; tbl_mrd = '0; reset = 1'b1;
      req_1 = 0; req_2 = 0; wr_1 = 0; wr_2 = 0;
      addr_1 = '0; addr_2 = '0; wdata_1 = '0; wdata_2 = '0;
      snoop_hit_1 = 0; snoop_hit_2 = 0;
      for (int i = 0; i < 32; i++) memarr[i] = $urandom;

      add(1,0,0,0,5,0,0,0,0,0,32'hDEADBEEF,8'b1000_0100,0,5,0,0,0);
      add(1,0,0,0,5,0,0,0,0,0,32'hDEADBEEF,8'b1000_0010,0,5,0,0,0);
      add(1,0,0,0,5,0,0,0,0,0,32'hDEADBEEF,8'b1000_0010,0,5,0,0,0);
      add(1,0,0,0,5,0,0,0,0,0,32'hDEADBEEF,8'b1010_0000,0,5,0,32'hDEADBEEF,0);
      add(0,0,0,0,5,0,0,0,0,0,0,8'b0,0,5,0,32'hDEADBEEF,0);
      add(0,1,0,1,0,9,0,32'h12345678,0,0,0,8'b0100_1000,1,9,32'h12345678,32'hDEADBEEF,0);
      add(0,1,0,1,0,9,0,32'h12345678,1,0,0,8'b0100_0011,1,9,32'h12345678,32'hDEADBEEF,1);
      add(0,1,0,1,0,9,0,32'h12345678,0,0,0,8'b0100_0011,1,9,32'h12345678,32'hDEADBEEF,1);
      add(0,1,0,1,0,9,0,32'h12345678,0,0,0,8'b0101_0000,1,9,32'h12345678,32'hDEADBEEF,1);
      add(0,0,0,0,0,9,0,0,0,0,0,8'b0,1,9,0,32'hDEADBEEF,1);
      add(1,1,0,0,1,2,0,0,0,1,32'hCAFEF00D,8'b1000_0100,0,1,0,32'hDEADBEEF,1);
      add(1,1,0,0,1,2,0,0,0,0,32'hCAFEF00D,8'b1000_0010,0,1,0,32'hDEADBEEF,0);
      add(1,1,0,0,1,2,0,0,0,0,32'hCAFEF00D,8'b1000_0010,0,1,0,32'hDEADBEEF,0);
      add(1,1,0,0,1,2,0,0,0,0,32'hCAFEF00D,8'b1010_0000,0,1,0,32'hCAFEF00D,0);
      add(0,1,0,0,1,2,0,0,0,0,0,8'b0,0,1,0,32'hCAFEF00D,0);
      add(0,1,0,0,1,2,0,0,0,0,32'h0BADC0DE,8'b0100_1000,0,2,0,32'hCAFEF00D,0);
      add(0,1,0,0,1,2,0,0,1,0,32'h0BADC0DE,8'b0100_0010,0,2,0,32'hCAFEF00D,1);
      add(0,1,0,0,1,2,0,0,0,0,32'h0BADC0DE,8'b0100_0010,0,2,0,32'hCAFEF00D,1);
      add(0,1,0,0,1,2,0,0,0,0,32'h0BADC0DE,8'b0101_0000,0,2,0,32'h0BADC0DE,1);
      add(0,0,0,0,1,2,0,0,0,0,0,8'b0,0,2,0,32'h0BADC0DE,1);

      @(negedge clk);
      chk("reset_ctl", ctl_now(), 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_shared", shared, 0);
      reset = 1'b0;

      foreach (tbl[i]) begin
         req_1 = tbl[i].r1; req_2 = tbl[i].r2;
         wr_1 = tbl[i].w1; wr_2 = tbl[i].w2;
         addr_1 = tbl[i].a1; addr_2 = tbl[i].a2;
         wdata_1 = tbl[i].d1; wdata_2 = tbl[i].d2;
         snoop_hit_1 = tbl[i].h1; snoop_hit_2 = tbl[i].h2;
         tbl_mrd = tbl[i].mrd;
         @(negedge clk);
         chk($sformatf("row%0d_ctl", i), ctl_now(), tbl[i].ctl);
         chk($sformatf("row%0d_rdata", i), rdata, tbl[i].erd);
         chk($sformatf("row%0d_shared", i), shared, tbl[i].esh);
         if (tbl[i].ctl[1])
            chk($sformatf("row%0d_maddr", i), mem_addr, tbl[i].ea);
         if (tbl[i].ctl[0])
            chk($sformatf("row%0d_mwdata", i), mem_wdata, tbl[i].ewd);
         if (tbl[i].ctl[3] | tbl[i].ctl[2]) begin
            chk($sformatf("row%0d_saddr", i), snoop_addr, tbl[i].ea);
            chk($sformatf("row%0d_swr", i), snoop_wr, tbl[i].sw);
         end
      end

      // reset asserted mid-cycle during a write access
      tbl_mode = 1'b0;
      snoop_hit_1 = 0; snoop_hit_2 = 0;
      req_1 = 1; wr_1 = 1; addr_1 = 5'd3; wdata_1 = 32'hAA;
      req_2 = 0; wr_2 = 0;
      wait_en("t6_en");
      chk("t6_we", mem_we, 1);
      #2 reset = 1'b1;
      #1;
      chk("t6_async_ctl", ctl_now(), 0);
      chk("t6_async_rdata", rdata, 0);
      chk("t6_async_shared", shared, 0);
      chk("t6_async_maddr", mem_addr, 0);
      chk("t6_async_mwdata", mem_wdata, 0);
      req_1 = 0;
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (done_1 | done_2 | mem_en) seen = 1;
      end
      chk("t6_no_done", seen, 0);

      // both requesting continuously: first tie to core 1, then alternate
      req_1 = 1; req_2 = 1; wr_1 = 0; wr_2 = 0;
      addr_1 = 5'd10; addr_2 = 5'd11;
      gap = 0; ovl = 0; prev = 0;
      repeat (30) begin
         @(negedge clk);
         if (gnt_1 && gnt_2) ovl = 1;
         if ((gnt_1 | gnt_2) && !prev) begin
            own_q.push_back(gnt_1 ? 1 : 2);
            if (own_q.size() > 1) gap_q.push_back(gap);
         end
         if (!(gnt_1 | gnt_2)) gap++;
         else gap = 0;
         prev = gnt_1 | gnt_2;
      end
      chk("t4_grants", own_q.size() >= 4, 1);
      for (int i = 0; i < 4; i++)
         if (i < own_q.size())
            chk($sformatf("t4_owner%0d", i), own_q[i], (i % 2 == 0) ? 1 : 2);
      chk("t4_overlap", ovl, 0);
      foreach (gap_q[i]) chk($sformatf("t4_gap%0d", i), gap_q[i], 1);
      req_1 = 0; req_2 = 0;
      repeat (8) @(negedge clk);

      // req_2 arriving while core 1 is in its memory access
      req_1 = 1; wr_1 = 0; addr_1 = 5'd7;
      wait_en("t5_en");
      req_2 = 1; wr_2 = 0; addr_2 = 5'd8;
      c = 0; cd = -1; cg = -1; bad = 0;
      while (c < 20 && cg < 0) begin
         @(negedge clk);
         c++;
         if (gnt_1 && gnt_2) bad = 1;
         if (done_1 && cd < 0) begin
            cd = c;
            chk("t5_rdata", rdata, memarr[7]);
            req_1 = 0;
         end
         if (gnt_2 && cg < 0) cg = c;
      end
      chk("t5_done1_seen", cd >= 0, 1);
      chk("t5_gnt2_delay", cg - cd, 2);
      chk("t5_overlap", bad, 0);
      n = 0;
      while (!done_2 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("t5_done2", done_2, 1);
      req_2 = 0;

      // random traffic against the reference model
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tcnt = 0; k_m = 0; last_m = 2; busy_m = 0; own2_m = 0;
      mw_m = 0; ma_m = '0; mwd_m = '0; rd_m = '0; sh_m = 0;
      idle1 = 0; idle2 = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         ec = exp_ctl();
         chk($sformatf("rnd%0d_ctl", cyc), ctl_now(), ec);
         chk($sformatf("rnd%0d_rdata", cyc), rdata, rd_m);
         chk($sformatf("rnd%0d_shared", cyc), shared, sh_m);
         if (ec[1]) chk($sformatf("rnd%0d_maddr", cyc), mem_addr, ma_m);
         if (ec[0]) chk($sformatf("rnd%0d_mwdata", cyc), mem_wdata, mwd_m);
         if (ec[3] | ec[2]) begin
            chk($sformatf("rnd%0d_saddr", cyc), snoop_addr, ma_m);
            chk($sformatf("rnd%0d_swr", cyc), snoop_wr, mw_m);
         end
         if (req_1) begin
            if (done_1) begin
               req_1 = 0;
               idle1 = $urandom_range(0, 3);
            end else if (gnt_1 && $urandom_range(0, 15) == 0) begin
               req_1 = 0;
               idle1 = 2;
            end
         end else if (idle1 > 0) begin
            idle1--;
         end else if ($urandom_range(0, 2) == 0) begin
            req_1 = 1;
            wr_1 = 1'($urandom_range(0, 1));
            addr_1 = AW'($urandom);
            wdata_1 = $urandom;
         end
         if (req_2) begin
            if (done_2) begin
               req_2 = 0;
               idle2 = $urandom_range(0, 3);
            end else if (gnt_2 && $urandom_range(0, 15) == 0) begin
               req_2 = 0;
               idle2 = 2;
            end
         end else if (idle2 > 0) begin
            idle2--;
         end else if ($urandom_range(0, 2) == 0) begin
            req_2 = 1;
            wr_2 = 1'($urandom_range(0, 1));
            addr_2 = AW'($urandom);
            wdata_2 = $urandom;
         end
         snoop_hit_1 = 1'($urandom_range(0, 1));
         snoop_hit_2 = 1'($urandom_range(0, 1));
         @(posedge clk);
         tcnt++;
         model_step();
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
